// File: rtl/sdram_burst_arbiter.sv
// Two-master round-robin arbiter for one Avalon-MM SDRAM burst port; grant held for a whole burst.
// One cycle from request to downstream command; data paths are zero-latency muxes; masters stall on waitrequest.
module sdram_burst_arbiter #(
  parameter int DATA_W  = 128,
  parameter int ADDR_W  = 32,
  parameter int BURST_W = 11,
  parameter int BE_W    = DATA_W / 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [ADDR_W-1:0]  m0_address,
  input  logic [BURST_W-1:0] m0_burstcount,
  input  logic               m0_read,
  input  logic               m0_write,
  input  logic [DATA_W-1:0]  m0_writedata,
  input  logic [BE_W-1:0]    m0_byteenable,
  output logic               m0_waitrequest,
  output logic [DATA_W-1:0]  m0_readdata,
  output logic               m0_readdatavalid,
  input  logic [ADDR_W-1:0]  m1_address,
  input  logic [BURST_W-1:0] m1_burstcount,
  input  logic               m1_read,
  input  logic               m1_write,
  input  logic [DATA_W-1:0]  m1_writedata,
  input  logic [BE_W-1:0]    m1_byteenable,
  output logic               m1_waitrequest,
  output logic [DATA_W-1:0]  m1_readdata,
  output logic               m1_readdatavalid,
  output logic [ADDR_W-1:0]  sdram_address,
  output logic [BURST_W-1:0] sdram_burstcount,
  output logic               sdram_read,
  output logic               sdram_write,
  output logic [DATA_W-1:0]  sdram_writedata,
  output logic [BE_W-1:0]    sdram_byteenable,
  input  logic               sdram_waitrequest,
  input  logic [DATA_W-1:0]  sdram_readdata,
  input  logic               sdram_readdatavalid,
  output logic [1:0]         grant,
  output logic               err
);

  typedef enum logic [1:0] {IDLE = 2'd0, RD_CMD = 2'd1, RD_DATA = 2'd2, WR = 2'd3} state_t;

  localparam logic [BURST_W-1:0] ONE = BURST_W'(1);

  state_t             state_q, state_d;
  logic [1:0]         grant_q, grant_d;
  logic               last_q, last_d;  // 1: m1 held the most recent grant
  logic [BURST_W-1:0] cnt_q, cnt_d;
  logic               err_q, err_d;

  logic               req0, req1, pick1, pick_read, pick_write;
  logic [BURST_W-1:0] pick_bc;
  logic               sel1, g_read, g_write;
  logic [ADDR_W-1:0]  g_address;
  logic [BURST_W-1:0] g_burstcount;
  logic [DATA_W-1:0]  g_writedata;
  logic [BE_W-1:0]    g_byteenable;

  assign req0       = m0_read | m0_write;
  assign req1       = m1_read | m1_write;
  assign pick1      = req1 && (!req0 || !last_q);
  assign pick_read  = pick1 ? m1_read : m0_read;
  assign pick_write = pick1 ? m1_write : m0_write;
  assign pick_bc    = pick1 ? m1_burstcount : m0_burstcount;

  assign sel1         = grant_q[1];
  assign g_read       = sel1 ? m1_read : m0_read;
  assign g_write      = sel1 ? m1_write : m0_write;
  assign g_address    = sel1 ? m1_address : m0_address;
  assign g_burstcount = sel1 ? m1_burstcount : m0_burstcount;
  assign g_writedata  = sel1 ? m1_writedata : m0_writedata;
  assign g_byteenable = sel1 ? m1_byteenable : m0_byteenable;

  assign m0_readdata = sdram_readdata;
  assign m1_readdata = sdram_readdata;
  assign grant       = grant_q;
  assign err         = err_q;

  always_comb begin
    state_d          = state_q;
    grant_d          = grant_q;
    last_d           = last_q;
    cnt_d            = cnt_q;
    err_d            = err_q;
    m0_waitrequest   = 1'b1;
    m1_waitrequest   = 1'b1;
    m0_readdatavalid = 1'b0;
    m1_readdatavalid = 1'b0;
    sdram_address    = '0;
    sdram_burstcount = '0;
    sdram_read       = 1'b0;
    sdram_write      = 1'b0;
    sdram_writedata  = '0;
    sdram_byteenable = '0;
    case (state_q)
      IDLE: begin
        if (sdram_readdatavalid) err_d = 1'b1;
        if (req0 || req1) begin
          if (pick_bc == '0) begin
            // Zero-length burst is swallowed with a one-cycle accept and flagged.
            err_d = 1'b1;
            if (rst_n) begin
              if (pick1) m1_waitrequest = 1'b0;
              else       m0_waitrequest = 1'b0;
            end
          end else begin
            grant_d = pick1 ? 2'b10 : 2'b01;
            last_d  = pick1;
            cnt_d   = pick_bc;
            if (pick_read) begin
              state_d = RD_CMD;
              if (pick_write) err_d = 1'b1;
            end else begin
              state_d = WR;
            end
          end
        end
      end
      RD_CMD: begin
        sdram_address    = g_address;
        sdram_burstcount = g_burstcount;
        sdram_read       = g_read;
        if (sel1) m1_waitrequest = sdram_waitrequest;
        else      m0_waitrequest = sdram_waitrequest;
        if (g_read && !sdram_waitrequest) state_d = RD_DATA;
      end
      RD_DATA: begin
        m0_readdatavalid = sdram_readdatavalid & grant_q[0];
        m1_readdatavalid = sdram_readdatavalid & grant_q[1];
        if (sdram_readdatavalid) begin
          if (cnt_q == ONE) begin
            state_d = IDLE;
            grant_d = 2'b00;
          end else begin
            cnt_d = cnt_q - ONE;
          end
        end
      end
      WR: begin
        sdram_address    = g_address;
        sdram_burstcount = g_burstcount;
        sdram_write      = g_write;
        sdram_writedata  = g_writedata;
        sdram_byteenable = g_byteenable;
        if (sel1) m1_waitrequest = sdram_waitrequest;
        else      m0_waitrequest = sdram_waitrequest;
        if (sdram_readdatavalid) err_d = 1'b1;
        // The master may idle between beats; only accepted beats count.
        if (g_write && !sdram_waitrequest) begin
          if (cnt_q == ONE) begin
            state_d = IDLE;
            grant_d = 2'b00;
          end else begin
            cnt_d = cnt_q - ONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= 2'b00;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

endmodule
